alg_amba_vip_apb_arbiter: RTL and testbench

Single-clock APB arbiter that shares one downstream APB completer port between `NUM_REQ` upstream APB requesters in the DCD Allegro testbench fabric. It grants requesters round-robin and replays the winner's transfer downstream as a clean SETUP/ACCESS sequence. It returns the completion to the winner with a one-cycle ready pulse, and converts a stuck downstream transfer into an error response after a programmable timeout.

---
 rtl/alg_amba_vip_apb_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_alg_amba_vip_apb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alg_amba_vip_apb_arbiter.sv
// Round-robin APB arbiter: shares one downstream completer between NUM_REQ requesters,
// replays the winner's transfer as SETUP/ACCESS and turns a stuck ACCESS into an error.
module alg_amba_vip_apb_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           s_sel,
   input  logic [NUM_REQ-1:0]           s_enable,
   input  logic [NUM_REQ-1:0]           s_write,
   input  logic [NUM_REQ*ADDR_W-1:0]    s_addr,
   input  logic [NUM_REQ*DATA_W-1:0]    s_wdata,
   output logic [NUM_REQ-1:0]           s_ready,
   output logic [DATA_W-1:0]            s_rdata,
   output logic                         s_slverr,
   output logic                         m_sel,
   output logic                         m_enable,
   output logic                         m_write,
   output logic [ADDR_W-1:0]            m_addr,
   output logic [DATA_W-1:0]            m_wdata,
   input  logic                         m_ready,
   input  logic                         m_slverr,
   input  logic [DATA_W-1:0]            m_rdata,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic                         timeout_err
);

   localparam int GID_W = $clog2(NUM_REQ);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_COMPLETE} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_m_sel, w_m_sel_nxt;
   logic                r_m_enable, w_m_enable_nxt;
   logic                r_m_write, w_m_write_nxt;
   logic [ADDR_W-1:0]   r_m_addr, w_m_addr_nxt;
   logic [DATA_W-1:0]   r_m_wdata, w_m_wdata_nxt;
   logic [NUM_REQ-1:0]  r_s_ready, w_s_ready_nxt;
   logic [DATA_W-1:0]   r_s_rdata, w_s_rdata_nxt;
   logic                r_s_slverr, w_s_slverr_nxt;
   logic [GID_W-1:0]    r_grant, w_grant_nxt;
   logic [GID_W-1:0]    r_last, w_last_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_tmo, w_tmo_nxt;
   logic [GID_W-1:0]    w_pick;
   logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];

   // Upstream penable plays no part in arbitration.
   logic w_unused;
   assign w_unused = ^s_enable;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = s_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = s_wdata[gi*DATA_W +: DATA_W];
   end

   // First requester above 'last' wins; otherwise wrap to the lowest requester.
   function automatic logic [GID_W-1:0] f_rr_pick(input logic [NUM_REQ-1:0] req,
                                                  input logic [GID_W-1:0]   last);
      logic             found_hi, found_lo;
      logic [GID_W-1:0] pick_hi, pick_lo;
      found_hi = 1'b0;
      found_lo = 1'b0;
      pick_hi  = '0;
      pick_lo  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (req[j] && !found_hi && (j > int'(last))) begin
            found_hi = 1'b1;
            pick_hi  = GID_W'(j);
         end
         if (req[j] && !found_lo) begin
            found_lo = 1'b1;
            pick_lo  = GID_W'(j);
         end
      end
      return found_hi ? pick_hi : pick_lo;
   endfunction

   assign w_pick = f_rr_pick(s_sel, r_last);

   // NOTE: every variable gets its default before the case, so no path can infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_m_sel_nxt    = r_m_sel;
      w_m_enable_nxt = r_m_enable;
      w_m_write_nxt  = r_m_write;
      w_m_addr_nxt   = r_m_addr;
      w_m_wdata_nxt  = r_m_wdata;
      w_s_ready_nxt  = '0;
      w_s_rdata_nxt  = r_s_rdata;
      w_s_slverr_nxt = 1'b0;
      w_grant_nxt    = r_grant;
      w_last_nxt     = r_last;
      w_cnt_nxt      = r_cnt;
      w_tmo_nxt      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|s_sel) begin
               w_m_addr_nxt   = w_addr_arr[w_pick];
               w_m_wdata_nxt  = w_wdata_arr[w_pick];
               w_m_write_nxt  = s_write[w_pick];
               w_m_sel_nxt    = 1'b1;
               w_m_enable_nxt = 1'b0;
               w_grant_nxt    = w_pick;
               w_last_nxt     = w_pick;
               w_state_nxt    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            w_m_enable_nxt = 1'b1;
            w_cnt_nxt      = '0;
            w_state_nxt    = ST_ACCESS;
         end
         ST_ACCESS: begin
            // A ready arriving on the final allowed cycle beats the timeout.
            if (r_m_sel && r_m_enable && m_ready) begin
               w_m_sel_nxt    = 1'b0;
               w_m_enable_nxt = 1'b0;
               w_s_ready_nxt  = NUM_REQ'(1) << r_grant;
               w_s_rdata_nxt  = m_rdata;
               w_s_slverr_nxt = m_slverr;
               w_state_nxt    = ST_COMPLETE;
            end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
               w_m_sel_nxt    = 1'b0;
               w_m_enable_nxt = 1'b0;
               w_s_ready_nxt  = NUM_REQ'(1) << r_grant;
               w_s_rdata_nxt  = '0;
               w_s_slverr_nxt = 1'b1;
               w_tmo_nxt      = 1'b1;
               w_state_nxt    = ST_COMPLETE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_COMPLETE: w_state_nxt = ST_IDLE;
         default:     w_state_nxt = ST_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_m_sel    <= 1'b0;
         r_m_enable <= 1'b0;
         r_m_write  <= 1'b0;
         r_m_addr   <= '0;
         r_m_wdata  <= '0;
         r_s_ready  <= '0;
         r_s_rdata  <= '0;
         r_s_slverr <= 1'b0;
         r_grant    <= '0;
         r_last     <= GID_W'(NUM_REQ - 1);
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_tmo      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_m_sel    <= w_m_sel_nxt;
         r_m_enable <= w_m_enable_nxt;
         r_m_write  <= w_m_write_nxt;
         r_m_addr   <= w_m_addr_nxt;
         r_m_wdata  <= w_m_wdata_nxt;
         r_s_ready  <= w_s_ready_nxt;
         r_s_rdata  <= w_s_rdata_nxt;
         r_s_slverr <= w_s_slverr_nxt;
         r_grant    <= w_grant_nxt;
         r_last     <= w_last_nxt;
         r_cnt      <= w_cnt_nxt;
         r_busy     <= w_busy_nxt;
         r_tmo      <= w_tmo_nxt;
      end
   end

   assign m_sel       = r_m_sel;
   assign m_enable    = r_m_enable;
   assign m_write     = r_m_write;
   assign m_addr      = r_m_addr;
   assign m_wdata     = r_m_wdata;
   assign s_ready     = r_s_ready;
   assign s_rdata     = r_s_rdata;
   assign s_slverr    = r_s_slverr;
   assign grant_id    = r_grant;
   assign busy        = r_busy;
   assign timeout_err = r_tmo;

endmodule

// File: tb/tb_alg_amba_vip_apb_arbiter.sv
// Scoreboard bench for the APB arbiter: stimulus queues expected grants and completions,
// a monitor pops and compares them as the DUT presents SETUP cycles and ready pulses.
module tb_alg_amba_vip_apb_arbiter;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct packed {
      logic [1:0]    id;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          wr;
   } grant_t;

   typedef struct packed {
      logic [1:0]    id;
      logic [DW-1:0] rdata;
      logic          slverr;
      logic          tmo;
   } cpl_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]    s_sel = '0;
   logic [NR-1:0]    s_write = '0;
   logic [NR-1:0]    s_enable;
   logic [NR*AW-1:0] s_addr = '0;
   logic [NR*DW-1:0] s_wdata = '0;
   logic             m_ready = 1'b0;
   logic             m_ready_z = 1'b0;
   logic [DW-1:0]    rsp_rdata = '0;
   logic             rsp_slverr = 1'b0;
   logic             rsp_hang = 1'b0;
   int               rsp_wait = 0;
   int               acc_cnt = 0;

   assign s_enable = s_sel;

   logic [NR-1:0] s_ready, z_s_ready;
   logic [DW-1:0] s_rdata, z_s_rdata;
   logic          s_slverr, z_s_slverr;
   logic          m_sel, m_enable, m_write, z_m_sel, z_m_enable, z_m_write;
   logic [AW-1:0] m_addr, z_m_addr;
   logic [DW-1:0] m_wdata, z_m_wdata;
   logic [1:0]    grant_id, z_grant_id;
   logic          busy, z_busy, timeout_err, z_timeout_err;

   alg_amba_vip_apb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) u_dut (
      .clk(clk), .rst(rst), .s_sel(s_sel), .s_enable(s_enable), .s_write(s_write),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata),
      .s_slverr(s_slverr), .m_sel(m_sel), .m_enable(m_enable), .m_write(m_write),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_slverr(rsp_slverr),
      .m_rdata(rsp_rdata), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err));

   // Same requesters, timeout disabled, with its own downstream ready.
   alg_amba_vip_apb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) u_dut_z (
      .clk(clk), .rst(rst), .s_sel(s_sel), .s_enable(s_enable), .s_write(s_write),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(z_s_ready), .s_rdata(z_s_rdata),
      .s_slverr(z_s_slverr), .m_sel(z_m_sel), .m_enable(z_m_enable), .m_write(z_m_write),
      .m_addr(z_m_addr), .m_wdata(z_m_wdata), .m_ready(m_ready_z), .m_slverr(rsp_slverr),
      .m_rdata(rsp_rdata), .grant_id(z_grant_id), .busy(z_busy), .timeout_err(z_timeout_err));

   int n_checks = 0;
   int n_errors = 0;
   grant_t grant_q[$];
   cpl_t   cpl_q[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Downstream completer: ready after rsp_wait wait cycles of ACCESS, never when hung.
   always @(negedge clk) begin
      if (m_sel && m_enable) acc_cnt = acc_cnt + 1;
      else acc_cnt = 0;
      m_ready = !rsp_hang && (acc_cnt > rsp_wait);
   end

   // Monitor: SETUP cycles pop the grant queue, ready pulses pop the completion queue.
   always @(negedge clk) begin
      if (m_sel && !m_enable) begin
         if (grant_q.size() == 0) check("grant_unexpected", {62'd0, grant_id}, 64'hFFFF);
         else begin
            grant_t g;
            g = grant_q.pop_front();
            check("grant_id", {62'd0, grant_id}, {62'd0, g.id});
            check("grant_addr", {32'd0, m_addr}, {32'd0, g.addr});
            check("grant_wdata", {32'd0, m_wdata}, {32'd0, g.wdata});
            check("grant_write", {63'd0, m_write}, {63'd0, g.wr});
         end
      end
      if (s_ready != '0) begin
         if (cpl_q.size() == 0) check("ready_unexpected", {60'd0, s_ready}, 64'd0);
         else begin
            cpl_t c;
            c = cpl_q.pop_front();
            check("cpl_ready", {60'd0, s_ready}, {60'd0, 4'b0001 << c.id});
            check("cpl_rdata", {32'd0, s_rdata}, {32'd0, c.rdata});
            check("cpl_slverr", {63'd0, s_slverr}, {63'd0, c.slverr});
            check("cpl_tmo", {63'd0, timeout_err}, {63'd0, c.tmo});
         end
      end
      if (timeout_err && s_ready == '0) check("tmo_without_ready", 64'd1, 64'd0);
   end

   task automatic do_reset();
      rst   = 1'b1;
      s_sel = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      s_write[i]         = wr;
      s_addr[i*AW +: AW] = a;
      s_wdata[i*DW +: DW] = d;
   endtask

   task automatic expect_xfer(input int i, input logic [DW-1:0] rd, input logic err,
                              input logic tmo);
      grant_q.push_back('{id: 2'(i), addr: s_addr[i*AW +: AW], wdata: s_wdata[i*DW +: DW],
                          wr: s_write[i]});
      cpl_q.push_back('{id: 2'(i), rdata: rd, slverr: err, tmo: tmo});
   endtask

   task automatic wait_ready(input int i);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 64 && !seen; c++) begin
         @(negedge clk);
         if (s_ready[i]) seen = 1'b1;
      end
      if (!seen) check("wait_ready_timeout", 64'd0, 64'd1);
      s_sel[i] = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_m_ctrl", {61'd0, m_sel, m_enable, m_write}, 64'd0);
      check("rst_m_addr_wdata", {m_addr, m_wdata}, 64'd0);
      check("rst_s_resp", {27'd0, s_ready, s_slverr, s_rdata}, 64'd0);
      check("rst_status", {60'd0, grant_id, busy, timeout_err}, 64'd0);

      // Single write from requester 2, zero-wait downstream
      rsp_hang = 1'b0; rsp_wait = 0; rsp_rdata = 32'h0BAD_F00D; rsp_slverr = 1'b0;
      set_req(2, 1'b1, 32'h40, 32'hDEAD_BEEF);
      expect_xfer(2, 32'h0BAD_F00D, 1'b0, 1'b0);
      s_sel[2] = 1'b1;
      step();
      check("single_msel_p1", {62'd0, m_sel, m_enable}, 64'b10);
      check("single_busy", {63'd0, busy}, 64'd1);
      step();
      check("single_menable_p2", {62'd0, m_sel, m_enable}, 64'b11);
      wait_ready(2);
      repeat (3) @(negedge clk);

      // Round robin with all requesters held: grants 0,1,2,3,0 every 4 cycles
      do_reset();
      rsp_rdata = 32'h5555_0000;
      for (int i = 0; i < NR; i++) set_req(i, i[0], 32'h1000 + 32'(i * 4), 32'h100 + 32'(i));
      for (int k = 0; k < 5; k++) expect_xfer(k % NR, 32'h5555_0000, 1'b0, 1'b0);
      s_sel = 4'b1111;
      for (int t = 0; t <= 16; t++) begin
         step();
         check($sformatf("rr_setup_t%0d", t), {63'd0, m_sel && !m_enable},
               {63'd0, (t % 4) == 0});
      end
      // Everyone drops while requester 0's transfer is in flight; it must still finish.
      s_sel = '0;
      repeat (6) @(negedge clk);

      // Read with 5 wait states and an error response
      rsp_wait = 5; rsp_rdata = 32'h1234_5678; rsp_slverr = 1'b1;
      set_req(1, 1'b0, 32'h100, 32'h0);
      expect_xfer(1, 32'h1234_5678, 1'b1, 1'b0);
      s_sel[1] = 1'b1;
      wait_ready(1);
      repeat (8) @(negedge clk);

      // Timeout with TIMEOUT=8; the TIMEOUT=0 instance must keep waiting
      do_reset();
      rsp_hang = 1'b1; m_ready_z = 1'b0; rsp_rdata = 32'hFFFF_FFFF; rsp_slverr = 1'b0;
      set_req(3, 1'b0, 32'h300, 32'h0);
      expect_xfer(3, 32'h0, 1'b1, 1'b1);
      s_sel[3] = 1'b1;
      for (int t = 0; t <= 9; t++) begin
         step();
         if (t == 8) check("tmo_msel_last_access", {63'd0, m_sel}, 64'd1);
         if (t == 9) check("tmo_msel_drop", {62'd0, m_sel, timeout_err}, 64'b01);
      end
      s_sel[3] = 1'b0;
      repeat (10) @(negedge clk);
      check("tmo0_still_waiting", {59'd0, z_m_sel, z_busy, z_s_ready}, {59'd0, 2'b11, 4'b0000});
      m_ready_z = 1'b1;
      step();
      m_ready_z = 1'b0;
      check("tmo0_complete", {25'd0, z_s_ready, z_timeout_err, z_s_slverr, z_s_rdata},
            {25'd0, 4'b1000, 1'b0, 1'b0, 32'hFFFF_FFFF});
      repeat (3) @(negedge clk);

      // Ready on the 8th ACCESS cycle wins over the timeout
      rsp_hang = 1'b0; rsp_wait = 7; rsp_rdata = 32'hCAFE_0001; rsp_slverr = 1'b0;
      set_req(0, 1'b1, 32'h500, 32'h77);
      expect_xfer(0, 32'hCAFE_0001, 1'b0, 1'b0);
      s_sel[0] = 1'b1;
      for (int t = 0; t <= 9; t++) begin
         step();
         if (t == 8) check("limit_msel_held", {63'd0, m_sel}, 64'd1);
         if (t == 9) check("limit_ready_no_tmo", {59'd0, s_ready, timeout_err}, {59'd0, 4'b0001, 1'b0});
      end
      s_sel[0] = 1'b0;
      repeat (3) @(negedge clk);

      // Reset while in ACCESS, then round-robin restarts from requester 0
      rsp_hang = 1'b1; rsp_wait = 0;
      set_req(0, 1'b0, 32'h600, 32'h0);
      grant_q.push_back('{id: 2'd0, addr: 32'h600, wdata: 32'h0, wr: 1'b0});
      s_sel[0] = 1'b1;
      repeat (3) step();
      rst = 1'b1;
      step();
      check("rst_mid_m_ctrl", {61'd0, m_sel, m_enable, m_write}, 64'd0);
      check("rst_mid_m_addr", {32'd0, m_addr}, 64'd0);
      check("rst_mid_s_resp", {27'd0, s_ready, s_slverr, s_rdata}, 64'd0);
      check("rst_mid_status", {60'd0, grant_id, busy, timeout_err}, 64'd0);
      rst = 1'b0;
      rsp_hang = 1'b0; rsp_rdata = 32'h600D_0006; rsp_slverr = 1'b0;
      set_req(2, 1'b1, 32'h620, 32'h62);
      expect_xfer(0, 32'h600D_0006, 1'b0, 1'b0);
      expect_xfer(2, 32'h600D_0006, 1'b0, 1'b0);
      s_sel = 4'b0101;
      wait_ready(0);
      wait_ready(2);
      repeat (4) @(negedge clk);

      check("grant_q_empty", 64'(grant_q.size()), 64'd0);
      check("cpl_q_empty", 64'(cpl_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
